// File: rtl/dm_pkg.sv
// Shared definitions for the dm_lanes data memory.
// Holds the access-size encodings, the controller state type and a helper
// that turns a size code into the number of bytes it touches.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_BAD  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dm_state_e;

  // Bytes touched by an access; the invalid code counts as one byte so the
  // range check stays well defined (it is rejected separately anyway).
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    unique case (sz)
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lanes_if.sv
// Request/response bundle between the pipeline (master) and dm_lanes (slave).
//   req, we, size, sign_ext, addr, wdata : request side, driven by master
//   ready, rdata, err                    : response side, driven by slave
interface dm_lanes_if;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ready, rdata, err
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ready, rdata, err
  );

endinterface

// File: rtl/dm_lane_fmt.sv
// Combinational lane formatter for the big-endian data memory.
//   fetch_i    : aligned word; [31:24] is the byte at the lowest address
//   size_i     : access size code
//   off_i      : addr[1:0] of the access
//   sign_ext_i : sign-extend byte/half loads
//   wdata_i    : right-justified store data
//   load_o     : right-justified, extended load value
//   wlanes_o   : store data replicated onto every lane it could land on
//   be_o       : store byte enables, bit 3 = lowest-address byte of the word
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [31:0] fetch_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] wlanes_o,
  output logic [3:0]  be_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    unique case (off_i)
      2'd0:    byte_v = fetch_i[31:24];
      2'd1:    byte_v = fetch_i[23:16];
      2'd2:    byte_v = fetch_i[15:8];
      default: byte_v = fetch_i[7:0];
    endcase
    half_v = off_i[1] ? fetch_i[15:0] : fetch_i[31:16];
  end

  always_comb begin
    load_o   = '0;
    wlanes_o = '0;
    be_o     = '0;
    unique case (size_i)
      SZ_BYTE: begin
        load_o   = {{24{sign_ext_i & byte_v[7]}}, byte_v};
        wlanes_o = {4{wdata_i[7:0]}};
        be_o     = 4'b1000 >> off_i;
      end
      SZ_HALF: begin
        load_o   = {{16{sign_ext_i & half_v[15]}}, half_v};
        wlanes_o = {2{wdata_i[15:0]}};
        be_o     = off_i[1] ? 4'b0011 : 4'b1100;
      end
      SZ_WORD: begin
        load_o   = fetch_i;
        wlanes_o = wdata_i;
        be_o     = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_lanes.sv
// Byte-addressable big-endian data memory with a req/ready handshake and a
// configurable number of wait states.
//   clk    : clock
//   rst    : asynchronous active-high reset (controller only, not contents)
//   bus_io : dm_lanes_if slave port (request in, registered response out)
// Parameters: DEPTH_BYTES (multiple of 4, at least 8), WAIT_STATES (0..15).
module dm_lanes
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  dm_lanes_if.slave  bus_io
);

  localparam int unsigned AW        = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  // Contents start at zero and are never touched by reset.
  logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

  dm_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        we_q, sext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        ready_q, err_q;
  logic [31:0] rdata_q;

  logic        acc_we, acc_sext;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic        do_access, acc_err, out_of_range;
  logic [32:0] last_byte;
  logic [31:0] fetch, load_val, wlanes;
  logic [3:0]  be;

  // With no wait states the access happens on the accepting edge, before the
  // request has been latched, so operands come straight from the bus in IDLE.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = bus_io.we;
      acc_sext  = bus_io.sign_ext;
      acc_size  = bus_io.size;
      acc_addr  = bus_io.addr;
      acc_wdata = bus_io.wdata;
    end else begin
      acc_we    = we_q;
      acc_sext  = sext_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  // The access is performed only on the edge that enters RESP.
  always_comb begin
    do_access = 1'b0;
    if (!rst) begin
      if (state_q == StIdle) begin
        do_access = bus_io.req && (WAIT_STATES == 0);
      end else if (state_q == StWait) begin
        do_access = (cnt_q == 4'd1);
      end
    end
  end

  always_comb begin
    last_byte    = {1'b0, acc_addr} + 33'(size_bytes(acc_size)) - 33'd1;
    out_of_range = last_byte >= 33'(DEPTH_BYTES);
    acc_err      = (acc_size == SZ_BAD) ||
                   ((acc_size == SZ_HALF) && acc_addr[0]) ||
                   ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00)) ||
                   out_of_range;
  end

  // Valid accesses never cross a word, so fetching the aligned word suffices.
  assign fetch = {mem_q[{acc_addr[AW-1:2], 2'd0}], mem_q[{acc_addr[AW-1:2], 2'd1}],
                  mem_q[{acc_addr[AW-1:2], 2'd2}], mem_q[{acc_addr[AW-1:2], 2'd3}]};

  dm_lane_fmt u_fmt (
    .fetch_i    (fetch),
    .size_i     (acc_size),
    .off_i      (acc_addr[1:0]),
    .sign_ext_i (acc_sext),
    .wdata_i    (acc_wdata),
    .load_o     (load_val),
    .wlanes_o   (wlanes),
    .be_o       (be)
  );

  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[3-k]) begin
          mem_q[{acc_addr[AW-1:2], 2'(k)}] <= wlanes[31-8*k -: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.req) begin
            we_q    <= bus_io.we;
            sext_q  <= bus_io.sign_ext;
            size_q  <= bus_io.size;
            addr_q  <= bus_io.addr;
            wdata_q <= bus_io.wdata;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_STATES == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StResp;
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (do_access) begin
        ready_q <= 1'b1;
        err_q   <= acc_err;
        rdata_q <= (acc_err || acc_we) ? 32'h0 : load_val;
      end
    end
  end

  assign bus_io.ready = ready_q;
  assign bus_io.rdata = rdata_q;
  assign bus_io.err   = err_q;

endmodule

// File: doc/dm_lanes.md
# dm_lanes

Parametrised, byte-addressable, big-endian data memory for the MIPS datapath, replacing the fixed 128-byte word-only data memory. It supports byte, halfword and word loads and stores, with optional sign extension on loads. A req/ready handshake with a configurable wait-state counter lets the pipeline be exercised against slow memory. Misaligned, out-of-range and invalid-size accesses are flagged and never commit.

## Interface
- DEPTH_BYTES, default 128: memory size in bytes; must be a multiple of 4.
- WAIT_STATES, default 0: extra cycles between request acceptance and response; range 0..15.
- clk  in  1: single clock; all state changes on posedge.
- rst  in  1: asynchronous, active-high reset.
- req  in  1: access request; held until ready.
- we  in  1: 1 = store, 0 = load; sampled with req.
- size  in  2: 0 = byte, 1 = half, 2 = word, 3 = invalid.
- sign_ext  in  1: load only; 1 = sign-extend byte/half, 0 = zero-extend.
- addr  in  32: byte address; byte at addr is the most significant byte of the accessed item.
- wdata  in  32: store data, right-justified (byte uses [7:0], half uses [15:0]).
- ready  out  1: one-cycle response strobe.
- rdata  out  32: load result; valid while ready=1.
- err  out  1: access rejected; valid while ready=1.

## Operation
- Clock and reset: one clock `clk`, reset `rst` asynchronous active-high.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On posedge with req=1, latch addr, we, size, sign_ext and wdata; load the wait counter with WAIT_STATES.
  - If WAIT_STATES=0, go directly to RESP and perform the access on that edge. Otherwise go to WAIT.
- WAIT: decrement the counter each edge. On the edge where the counter reaches 0, perform the access and go to RESP.
- RESP: ready=1 for exactly one cycle, then IDLE. req is ignored in RESP; a still-high req is accepted as a new request in the following IDLE cycle.
- Error check, applied to latched values when the access is performed:
  - size=3.
  - size=1 with addr[0]=1.
  - size=2 with addr[1:0]≠0.
  - Any touched byte index ≥ DEPTH_BYTES.
  - On error: err=1, rdata=0, memory unchanged.
- Store layout (big-endian):
  - byte: wdata[7:0] → M[a].
  - half: [15:8] → M[a], [7:0] → M[a+1].
  - word: [31:24] → M[a] … [7:0] → M[a+3].
- Load layout, same byte order: right-justify the result; upper bits zero, or copies of the item MSB if sign_ext=1. sign_ext is ignored for word loads.
- A store returns rdata=0 with ready.
- Memory contents:
  - Zero at time 0.
  - Unaffected by rst.

## Timing
- Reset values: ready=0, err=0, rdata=0, state=IDLE, counter=0.
- Reset mid-operation: the pending access is aborted and no store commits, because the store is written only on the edge that enters RESP.
- Latency: ready rises WAIT_STATES+1 cycles after the accepting edge.
- Throughput: one access per WAIT_STATES+2 cycles.
- Memory write and registered rdata/err update on the same posedge. Outputs are registered, with no combinational path from inputs to outputs.
- A load issued right after a store to the same address returns the new data, since the store completes before the load is accepted.

## Structure
- Shared package dm_pkg:
  - Size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - State enum.
- Sub-module dm_lane_fmt (combinational): takes the 4 fetched bytes, size, addr[1:0] and sign_ext, and produces the 32-bit load value and the store byte-enable mask. The FSM, counter and byte array live in dm_lanes.

## Test plan
- WAIT_STATES=0: store word 0x11223344 @0x10, then load word @0x10 → ready 1 cycle after each accept; rdata=0x11223344, err=0.
- Load byte @0x11 with sign_ext=1 after storing 0x80FF0000 @0x10 → rdata=0xFFFFFFFF. Same with sign_ext=0 → 0x000000FF. Half @0x10 signed → 0xFFFF80FF.
- Store half 0xABCD @0x13 → err=1 (misaligned); word @0x10 reads back unchanged. Word access @DEPTH_BYTES-2 → err=1. size=3 → err=1.
- WAIT_STATES=3: req held high continuously → ready pulses exactly every 5 cycles, each one cycle wide.
- WAIT_STATES=3: store 0xDEADBEEF @0x20, assert rst during WAIT → ready=0 and state=IDLE immediately; a later load @0x20 returns the prior contents (0).
